// File: rtl/fir_tap_mac.sv
// Time-multiplexed transposed-form FIR MAC: one shared multiplier walks all taps per sample strobe
// and presents a rounded, saturated Q1.15 result to the downstream sum stage.
//
// state | meaning
// IDLE  | waiting for a sample strobe; coefficient writes accepted
// MAC   | one tap per cycle, k ascending, updating y and the partial sums z
// DONE  | round/saturate y into oMac1, then return to IDLE
module fir_tap_mac #(
  parameter int TAPS  = 33,
  parameter int ACC_W = 38
) (
  input  logic        iClk_12M,
  input  logic        iRsn,
  input  logic        iEnSample_300k,
  input  logic [15:0] iFirIn,
  input  logic        iCoefWe,
  input  logic [5:0]  iCoefAddr,
  input  logic [15:0] iCoefData,
  output logic [15:0] oMac1,
  output logic        oEnDelay,
  output logic        oBusy,
  output logic        oOverrun
);

  localparam int KW = (TAPS > 2) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_next;

  logic [KW-1:0]           k;
  logic signed [15:0]      h [TAPS];
  logic signed [ACC_W-1:0] z [TAPS-1];
  logic signed [ACC_W-1:0] z_up [TAPS-1];
  logic signed [15:0]      x;
  logic signed [ACC_W-1:0] y;

  logic signed [15:0]      h_k;
  logic signed [31:0]      h_ext;
  logic signed [31:0]      x_ext;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] p;
  logic                    last_tap;
  logic                    coef_ok;

  logic signed [ACC_W-1:0] y_rnd;
  logic signed [ACC_W-1:0] r;
  logic                    ovf;
  logic [15:0]             result;

  assign h_k      = h[k];
  assign h_ext    = {{16{h_k[15]}}, h_k};
  assign x_ext    = {{16{x[15]}}, x};
  assign prod     = h_ext * x_ext;
  assign p        = {{(ACC_W-32){prod[31]}}, prod};
  assign last_tap = (k == KW'(TAPS-1));
  assign coef_ok  = (iCoefAddr < 6'(TAPS));

  // z_up[i] is the old z[i+1]; the last partial sum has no upstream neighbour.
  for (genvar i = 0; i < TAPS-1; i++) begin : g_zup
    if (i < TAPS-2) begin : g_mid
      assign z_up[i] = z[i+1];
    end else begin : g_last
      assign z_up[i] = '0;
    end
  end

  assign y_rnd  = y + {{(ACC_W-15){1'b0}}, 1'b1, 14'b0};
  assign r      = y_rnd >>> 15;
  assign ovf    = ~((&r[ACC_W-1:15]) | ~(|r[ACC_W-1:15]));
  assign result = ovf ? (r[ACC_W-1] ? 16'h8000 : 16'h7FFF) : r[15:0];

  assign oBusy = (state != IDLE);

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iEnSample_300k) state_next = MAC;
      MAC:     if (last_tap)       state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      k        <= '0;
      x        <= '0;
      y        <= '0;
      oMac1    <= '0;
      oEnDelay <= 1'b0;
      oOverrun <= 1'b0;
      for (int i = 0; i < TAPS; i++)   h[i] <= '0;
      for (int i = 0; i < TAPS-1; i++) z[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // a strobe takes priority over a simultaneous coefficient write
          if (iEnSample_300k) begin
            x <= iFirIn;
            k <= '0;
          end else if (iCoefWe && coef_ok) begin
            h[iCoefAddr[KW-1:0]] <= iCoefData;
          end
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == '0) y <= p + z[0];
          for (int i = 0; i < TAPS-1; i++) begin
            if (k == KW'(i+1)) z[i] <= p + z_up[i];
          end
        end
        DONE: begin
          oMac1    <= result;
          oEnDelay <= 1'b1;
        end
        default: ;
      endcase
      if (iEnSample_300k && (state != IDLE)) oOverrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_tap_mac.sv
// Randomized scoreboard bench for fir_tap_mac: a convolution model predicts every output, a
// monitor compares each result as oBusy falls.
module tb_fir_tap_mac;

  localparam int TAPS  = 33;
  localparam int ACC_W = 38;

  logic        clk = 1'b0;
  logic        rsn = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [15:0] din = '0;
  logic [5:0]  caddr = '0;
  logic [15:0] cdata = '0;
  logic [15:0] mac;
  logic        en_dly;
  logic        busy;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  fir_tap_mac #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .iClk_12M(clk), .iRsn(rsn), .iEnSample_300k(en), .iFirIn(din),
    .iCoefWe(we), .iCoefAddr(caddr), .iCoefData(cdata),
    .oMac1(mac), .oEnDelay(en_dly), .oBusy(busy), .oOverrun(ovr)
  );

  always #5 clk = ~clk;

  // Model: each accepted sample remembers the coefficient set in force when it arrived, since
  // its products are formed at that moment. y(n) = sum_i h_then[i] * x(n-i).
  logic signed [15:0]  mh [TAPS];
  logic [15:0]         hx [$];
  logic [TAPS*16-1:0]  hs [$];
  logic [15:0]         exp_q [$];

  function automatic logic [15:0] ref_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < hx.size(); i++) begin
      logic signed [15:0] xv;
      logic signed [15:0] cv;
      xv = hx[i];
      cv = hs[i][i*16 +: 16];
      acc += longint'(xv) * longint'(cv);
    end
    acc = (acc + 16384) >>> 15;
    if (acc > 32767)  return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  task automatic push_sample(input logic [15:0] xv);
    logic [TAPS*16-1:0] s;
    for (int i = 0; i < TAPS; i++) s[i*16 +: 16] = mh[i];
    hx.push_front(xv);
    hs.push_front(s);
    if (hx.size() > TAPS) begin
      void'(hx.pop_back());
      void'(hs.pop_back());
    end
    exp_q.push_back(ref_out());
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rsn) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", mac);
        end else begin
          check("scoreboard_mac", mac, exp_q.pop_front());
          check("en_delay_held", {15'b0, en_dly}, 16'h0001);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic write_coef(input int a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; caddr = 6'(a); cdata = d;
    @(negedge clk);
    we = 1'b0;
    if (a < TAPS) mh[a] = d;
  endtask

  task automatic strobe(input logic [15:0] xv, input int gap);
    @(negedge clk);
    en = 1'b1; din = xv;
    push_sample(xv);
    @(negedge clk);
    en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rsn = 1'b0;
    #1;
    check("rst_mac", mac, 16'h0000);
    check("rst_en_delay", {15'b0, en_dly}, 16'h0000);
    check("rst_busy", {15'b0, busy}, 16'h0000);
    check("rst_overrun", {15'b0, ovr}, 16'h0000);
    for (int i = 0; i < TAPS; i++) mh[i] = '0;
    hx.delete();
    hs.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rsn = 1'b1;
  endtask

  function automatic logic [15:0] rand_coef();
    logic signed [15:0] s;
    s = 16'($urandom);
    return s >>> $urandom_range(0, 5);
  endfunction

  initial begin
    int lat;
    int n;

    do_reset();

    // impulse with all taps at 0.5, plus latency to the first output
    for (int a = 0; a < TAPS; a++) write_coef(a, 16'h4000);
    write_coef(40, 16'h1234);
    @(negedge clk);
    en = 1'b1; din = 16'h4000;
    push_sample(16'h4000);
    @(posedge clk);
    #1 en = 1'b0;
    lat = 0;
    while (!en_dly && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("en_delay_latency", 16'(lat), 16'd34);
    check("impulse_first", mac, 16'h2000);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 35; i++) strobe(16'h0000, 38);

    // tap ordering
    for (int a = 0; a < TAPS; a++) write_coef(a, 16'(a + 1));
    strobe(16'h7FFF, 38);
    check("order_first", mac, 16'h0001);
    for (int i = 0; i < 34; i++) strobe(16'h0000, 38);

    // saturation both ways
    for (int a = 0; a < TAPS; a++) write_coef(a, 16'h7FFF);
    for (int i = 0; i < 40; i++) strobe(16'h7FFF, 38);
    check("sat_pos", mac, 16'h7FFF);
    for (int i = 0; i < 40; i++) strobe(16'h8000, 38);
    check("sat_neg", mac, 16'h8000);

    // rounding with a single LSB tap
    for (int a = 0; a < TAPS; a++) write_coef(a, (a == 0) ? 16'h0001 : 16'h0000);
    for (int i = 0; i < 33; i++) strobe(16'h0000, 38);
    strobe(16'h4000, 38);
    check("round_half_up", mac, 16'h0001);
    strobe(16'h3FFF, 38);
    check("round_below_half", mac, 16'h0000);
    strobe(16'hC000, 38);
    check("round_neg_half", mac, 16'h0000);

    // overrun strobe and a coefficient write while busy are both dropped
    check("overrun_clear", {15'b0, ovr}, 16'h0000);
    @(negedge clk);
    en = 1'b1; din = 16'h4000;
    push_sample(16'h4000);
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    en = 1'b1; din = 16'h8000;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    we = 1'b1; caddr = 6'd0; cdata = 16'h7FFF;
    @(negedge clk);
    we = 1'b0;
    repeat (40) @(negedge clk);
    check("overrun_set", {15'b0, ovr}, 16'h0001);
    check("overrun_result", mac, 16'h0001);
    strobe(16'h7FFF, 38);
    check("write_lockout", mac, 16'h0001);

    // randomized coefficients, samples, idle writes and strobe spacing
    for (int a = 0; a < TAPS; a++) write_coef(a, rand_coef());
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, 63), rand_coef());
      strobe(16'($urandom), $urandom_range(38, 48));
    end

    // reset mid-MAC clears everything, including coefficients
    @(negedge clk);
    en = 1'b1; din = 16'h4000;
    push_sample(16'h4000);
    @(negedge clk);
    en = 1'b0;
    repeat (13) @(negedge clk);
    do_reset();
    strobe(16'h4000, 38);
    check("post_reset_zero", mac, 16'h0000);
    for (int i = 0; i < 3; i++) strobe(16'h0000, 38);
    for (int a = 0; a < TAPS; a++) write_coef(a, 16'h4000);
    strobe(16'h4000, 38);
    check("reload_impulse", mac, 16'h2000);
    for (int i = 0; i < 34; i++) strobe(16'h0000, 38);

    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
